// File: rtl/ldpc_pkg.sv
// Shared LDPC scheduler definitions: state encodings, default code length, clog2 helper.
package ldpc_pkg;

  localparam int unsigned CODE_LEN = 256;

  typedef enum logic [2:0] {
    STATE_SCHED_IDLE          = 3'd0,
    STATE_SCHED_WAIT_ENC      = 3'd1,
    STATE_SCHED_WAIT_DEC_ACC  = 3'd2,
    STATE_SCHED_WAIT_DEC_DONE = 3'd3,
    STATE_SCHED_COUNT         = 3'd4,
    STATE_SCHED_REPORT        = 3'd5,
    STATE_SCHED_FINISH        = 3'd6
  } sched_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ldpc_popcount.sv
// Combinational popcount built as a recursive binary adder tree.
module ldpc_popcount
  import ldpc_pkg::*;
#(
  parameter int unsigned W  = CODE_LEN,
  parameter int unsigned OW = clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [OW-1:0] cnt_o
);

  if (W == 1) begin : g_leaf
    assign cnt_o = OW'(vec_i);
  end else begin : g_node
    localparam int unsigned WL  = W / 2;
    localparam int unsigned WH  = W - WL;
    localparam int unsigned OWL = clog2(WL + 1);
    localparam int unsigned OWH = clog2(WH + 1);

    logic [OWL-1:0] cnt_lo;
    logic [OWH-1:0] cnt_hi;

    ldpc_popcount #(.W(WL), .OW(OWL)) u_lo (.vec_i(vec_i[WL-1:0]), .cnt_o(cnt_lo));
    ldpc_popcount #(.W(WH), .OW(OWH)) u_hi (.vec_i(vec_i[W-1:WL]), .cnt_o(cnt_hi));

    assign cnt_o = OW'(cnt_lo) + OW'(cnt_hi);
  end

endmodule

// File: rtl/ldpc_frame_scheduler.sv
// BER sweep sequencer: frames x noise points through encoder/decoder handshakes, per-point error stats.
// Define LDPC_EARLY_STOP_EN to end a noise point once its frame-error count reaches FER_THRESH.
module ldpc_frame_scheduler
  import ldpc_pkg::*;
#(
  parameter int unsigned CodeLen               = CODE_LEN,
  parameter int unsigned Iteration_Times       = 50,
  parameter int unsigned Sigma_Iteration_Times = 20,
  parameter int unsigned SIGMA_W               = 5,
  parameter int unsigned ERR_W                 = 16,
  parameter int unsigned FER_THRESH            = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               gen_enable,
  input  logic               generate_code_down,
  input  logic [CodeLen-1:0] Code_sequence,
  output logic               generate_code_down_receive,
  output logic               dec_start,
  output logic [CodeLen-1:0] dec_codeword,
  output logic [SIGMA_W-1:0] dec_sigma_idx,
  input  logic               dec_start_receive,
  input  logic               dec_done,
  input  logic [CodeLen-1:0] dec_result,
  output logic               dec_done_receive,
  output logic               stat_valid,
  output logic [ERR_W-1:0]   stat_bit_err,
  output logic [7:0]         stat_frame_err,
  output logic               busy,
  output logic               sweep_done
);

  localparam int unsigned FRAME_W = (Iteration_Times > 1) ? clog2(Iteration_Times) : 1;
  localparam int unsigned CNT_W   = clog2(CodeLen + 1);
  localparam int unsigned SUM_W   = ERR_W + 1;

`ifdef LDPC_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  localparam logic [7:0]         FER_LIMIT  = 8'(FER_THRESH);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(Iteration_Times - 1);
  localparam logic [SIGMA_W-1:0] SIGMA_LAST = SIGMA_W'(Sigma_Iteration_Times - 1);

  sched_state_e       state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [SIGMA_W-1:0] sigma_q, sigma_d;
  logic [ERR_W-1:0]   bit_acc_q, bit_acc_d;
  logic [7:0]         fer_q, fer_d;
  logic [CodeLen-1:0] diff_q, diff_d;
  logic [CodeLen-1:0] codeword_q, codeword_d;
  logic               gen_en_q, gen_en_d;
  logic               enc_ack_q, enc_ack_d;
  logic               dec_start_q, dec_start_d;
  logic               dec_ack_q, dec_ack_d;
  logic               stat_valid_q, stat_valid_d;
  logic [ERR_W-1:0]   stat_bit_q, stat_bit_d;
  logic [7:0]         stat_fer_q, stat_fer_d;
  logic               busy_q, busy_d;
  logic               sweep_done_q, sweep_done_d;

  logic [CNT_W-1:0]   pop_cnt;
  logic [SUM_W-1:0]   bit_sum_c;
  logic [ERR_W-1:0]   bit_acc_sat_c;
  logic [7:0]         fer_inc_c;

  ldpc_popcount #(.W(CodeLen), .OW(CNT_W)) u_popcount (
    .vec_i (diff_q),
    .cnt_o (pop_cnt)
  );

  // Saturating accumulator updates consumed in COUNT.
  assign bit_sum_c     = {1'b0, bit_acc_q} + SUM_W'(pop_cnt);
  assign bit_acc_sat_c = bit_sum_c[ERR_W] ? '1 : bit_sum_c[ERR_W-1:0];
  assign fer_inc_c     = (fer_q == 8'hFF) ? fer_q : fer_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STATE_SCHED_IDLE;
      frame_q      <= '0;
      sigma_q      <= '0;
      bit_acc_q    <= '0;
      fer_q        <= '0;
      diff_q       <= '0;
      codeword_q   <= '0;
      gen_en_q     <= 1'b0;
      enc_ack_q    <= 1'b0;
      dec_start_q  <= 1'b0;
      dec_ack_q    <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_bit_q   <= '0;
      stat_fer_q   <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      sigma_q      <= sigma_d;
      bit_acc_q    <= bit_acc_d;
      fer_q        <= fer_d;
      diff_q       <= diff_d;
      codeword_q   <= codeword_d;
      gen_en_q     <= gen_en_d;
      enc_ack_q    <= enc_ack_d;
      dec_start_q  <= dec_start_d;
      dec_ack_q    <= dec_ack_d;
      stat_valid_q <= stat_valid_d;
      stat_bit_q   <= stat_bit_d;
      stat_fer_q   <= stat_fer_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    sigma_d      = sigma_q;
    bit_acc_d    = bit_acc_q;
    fer_d        = fer_q;
    diff_d       = diff_q;
    codeword_d   = codeword_q;
    enc_ack_d    = 1'b0;
    dec_ack_d    = 1'b0;
    stat_valid_d = 1'b0;
    stat_bit_d   = stat_bit_q;
    stat_fer_d   = stat_fer_q;

    case (state_q)
      STATE_SCHED_IDLE: begin
        if (start) begin
          frame_d   = '0;
          sigma_d   = '0;
          bit_acc_d = '0;
          fer_d     = '0;
          state_d   = STATE_SCHED_WAIT_ENC;
        end
      end
      STATE_SCHED_WAIT_ENC: begin
        if (generate_code_down) begin
          codeword_d = Code_sequence;
          enc_ack_d  = 1'b1;
          state_d    = STATE_SCHED_WAIT_DEC_ACC;
        end
      end
      STATE_SCHED_WAIT_DEC_ACC: begin
        if (dec_start_receive) state_d = STATE_SCHED_WAIT_DEC_DONE;
      end
      STATE_SCHED_WAIT_DEC_DONE: begin
        if (dec_done) begin
          diff_d    = dec_result ^ codeword_q;
          dec_ack_d = 1'b1;
          state_d   = STATE_SCHED_COUNT;
        end
      end
      STATE_SCHED_COUNT: begin
        bit_acc_d = bit_acc_sat_c;
        if (pop_cnt != '0) fer_d = fer_inc_c;
        // Stats are captured here so they are valid during the REPORT cycle.
        if ((frame_q == FRAME_LAST) ||
            (EARLY_STOP && (pop_cnt != '0) && (fer_inc_c == FER_LIMIT))) begin
          stat_valid_d = 1'b1;
          stat_bit_d   = bit_acc_d;
          stat_fer_d   = fer_d;
          state_d      = STATE_SCHED_REPORT;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
          state_d = STATE_SCHED_WAIT_ENC;
        end
      end
      STATE_SCHED_REPORT: begin
        bit_acc_d = '0;
        fer_d     = '0;
        frame_d   = '0;
        if (sigma_q == SIGMA_LAST) begin
          state_d = STATE_SCHED_FINISH;
        end else begin
          sigma_d = sigma_q + SIGMA_W'(1);
          state_d = STATE_SCHED_WAIT_ENC;
        end
      end
      STATE_SCHED_FINISH: state_d = STATE_SCHED_IDLE;
      default:            state_d = STATE_SCHED_IDLE;
    endcase

    // Level outputs follow the state being entered so they are registered.
    gen_en_d     = (state_d == STATE_SCHED_WAIT_ENC);
    dec_start_d  = (state_d == STATE_SCHED_WAIT_DEC_ACC);
    busy_d       = (state_d != STATE_SCHED_IDLE) && (state_d != STATE_SCHED_FINISH);
    sweep_done_d = (state_q == STATE_SCHED_REPORT) && (state_d == STATE_SCHED_FINISH);
  end

  assign gen_enable                 = gen_en_q;
  assign generate_code_down_receive = enc_ack_q;
  assign dec_start                  = dec_start_q;
  assign dec_codeword               = codeword_q;
  assign dec_sigma_idx              = sigma_q;
  assign dec_done_receive           = dec_ack_q;
  assign stat_valid                 = stat_valid_q;
  assign stat_bit_err               = stat_bit_q;
  assign stat_frame_err             = stat_fer_q;
  assign busy                       = busy_q;
  assign sweep_done                 = sweep_done_q;

endmodule

// File: tb/tb_ldpc_frame_scheduler.sv
// Directed bench for ldpc_frame_scheduler: 4 frames x 2 noise points with behavioural encoder/decoder.
module tb_ldpc_frame_scheduler;

  localparam int unsigned CL = 256;
  localparam int unsigned IT = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned SW = 5;
  localparam int unsigned EW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          gen_enable;
  logic          generate_code_down = 1'b0;
  logic [CL-1:0] Code_sequence = '0;
  logic          generate_code_down_receive;
  logic          dec_start;
  logic [CL-1:0] dec_codeword;
  logic [SW-1:0] dec_sigma_idx;
  logic          dec_start_receive = 1'b0;
  logic          dec_done = 1'b0;
  logic [CL-1:0] dec_result = '0;
  logic          dec_done_receive;
  logic          stat_valid;
  logic [EW-1:0] stat_bit_err;
  logic [7:0]    stat_frame_err;
  logic          busy;
  logic          sweep_done;

  ldpc_frame_scheduler #(
    .CodeLen(CL), .Iteration_Times(IT), .Sigma_Iteration_Times(ST),
    .SIGMA_W(SW), .ERR_W(EW), .FER_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .gen_enable(gen_enable),
    .generate_code_down(generate_code_down), .Code_sequence(Code_sequence),
    .generate_code_down_receive(generate_code_down_receive),
    .dec_start(dec_start), .dec_codeword(dec_codeword), .dec_sigma_idx(dec_sigma_idx),
    .dec_start_receive(dec_start_receive), .dec_done(dec_done), .dec_result(dec_result),
    .dec_done_receive(dec_done_receive), .stat_valid(stat_valid),
    .stat_bit_err(stat_bit_err), .stat_frame_err(stat_frame_err),
    .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: counts handshake pulses and records every reported stat.
  int            ack_cnt = 0, dack_cnt = 0, sd_cnt = 0, sig_viol = 0;
  logic [EW-1:0] be_q[$];
  logic [7:0]    fe_q[$];
  logic [SW-1:0] sig_prev = '0;

  always @(posedge clk) begin
    #1;
    if (generate_code_down_receive) ack_cnt <= ack_cnt + 1;
    if (dec_done_receive) dack_cnt <= dack_cnt + 1;
    if (sweep_done) sd_cnt <= sd_cnt + 1;
    if (stat_valid) begin
      be_q.push_back(stat_bit_err);
      fe_q.push_back(stat_frame_err);
    end
    if (dec_start && (dec_sigma_idx != sig_prev)) sig_viol <= sig_viol + 1;
    sig_prev <= dec_sigma_idx;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return generate_code_down_receive;
      1:       return dec_done_receive;
      default: return sweep_done;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string tag);
    int n;
    n = 0;
    while (!sig(w) && n < 200) begin
      tick();
      n++;
    end
    if (!sig(w)) check(tag, 64'd0, 64'd1);
  endtask

  function automatic logic [CL-1:0] rand_cw();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_gen_en"},    64'(gen_enable), 64'd0);
    check({pfx, "_enc_ack"},   64'(generate_code_down_receive), 64'd0);
    check({pfx, "_dec_start"}, 64'(dec_start), 64'd0);
    check({pfx, "_codeword"},  64'(dec_codeword == '0), 64'd1);
    check({pfx, "_sigma"},     64'(dec_sigma_idx), 64'd0);
    check({pfx, "_dec_ack"},   64'(dec_done_receive), 64'd0);
    check({pfx, "_stat_v"},    64'(stat_valid), 64'd0);
    check({pfx, "_stat_be"},   64'(stat_bit_err), 64'd0);
    check({pfx, "_stat_fe"},   64'(stat_frame_err), 64'd0);
    check({pfx, "_busy"},      64'(busy), 64'd0);
    check({pfx, "_sweep_dn"},  64'(sweep_done), 64'd0);
  endtask

  // One frame: encoder handshake, decoder offer (optionally delayed accept), decoder result.
  task automatic do_frame(input logic [CL-1:0] cw, input logic [CL-1:0] flip,
                          input int acc_dly, input int exp_sigma, input bit last);
    int bad;
    Code_sequence      = cw;
    generate_code_down = 1'b1;
    wait_sig(0, "enc_ack_timeout");
    tick();
    generate_code_down = 1'b0;
    bad = 0;
    for (int i = 0; i <= acc_dly; i++) begin
      if (dec_start !== 1'b1 || dec_codeword !== cw || dec_sigma_idx !== SW'(exp_sigma)) bad++;
      if (i < acc_dly) tick();
    end
    check("dec_offer_stable", 64'(bad), 64'd0);
    dec_start_receive = 1'b1;
    tick();
    dec_start_receive = 1'b0;
    check("dec_start_drop", 64'(dec_start), 64'd0);
    dec_result = cw ^ flip;
    dec_done   = 1'b1;
    wait_sig(1, "dec_ack_timeout");
    dec_done = 1'b0;
    if (last) begin
      tick();
      check("stat_latency", 64'(stat_valid), 64'd1);
    end
  endtask

  task automatic do_sweep(input int fpp, input int flip_pt, input int flip_fr,
                          input logic [CL-1:0] flip, input int dly_fr, input bit pre_hold);
    logic [CL-1:0] cw, fl;
    cw = rand_cw();
    if (pre_hold) begin
      Code_sequence      = cw;
      generate_code_down = 1'b1;
      repeat (5) begin
        tick();
        check("prehold_no_ack", 64'(generate_code_down_receive), 64'd0);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_gen_en", 64'(gen_enable), 64'd1);
    if (pre_hold) begin
      tick();
      check("enc_ack_latency", 64'(generate_code_down_receive), 64'd1);
    end
    for (int p = 0; p < int'(ST); p++) begin
      for (int f = 0; f < fpp; f++) begin
        if (p != 0 || f != 0) cw = rand_cw();
        fl = ((flip_pt < 0 || p == flip_pt) && (flip_fr < 0 || f == flip_fr)) ? flip : '0;
        do_frame(cw, fl, (p == 0 && f == dly_fr) ? 10 : 0, p, f == fpp - 1);
      end
    end
  endtask

  task automatic expect_sweep(input int b_st, input int b_sd, input int b_ack, input int b_dack,
                              input int frames, input int be0, input int fe0,
                              input int be1, input int fe1);
    int n;
    n = 0;
    while (sd_cnt == b_sd && n < 100) begin
      tick();
      n++;
    end
    tick();
    #2;
    check("sweep_done_cnt", 64'(sd_cnt - b_sd), 64'd1);
    check("enc_ack_cnt", 64'(ack_cnt - b_ack), 64'(frames));
    check("dec_ack_cnt", 64'(dack_cnt - b_dack), 64'(frames));
    check("stat_cnt", 64'(be_q.size() - b_st), 64'(ST));
    check("end_busy", 64'(busy), 64'd0);
    check("end_sigma", 64'(dec_sigma_idx), 64'(ST - 1));
    if (be_q.size() == b_st + int'(ST)) begin
      check("pt0_bit_err", 64'(be_q[b_st]), 64'(be0));
      check("pt0_frame_err", 64'(fe_q[b_st]), 64'(fe0));
      check("pt1_bit_err", 64'(be_q[b_st + 1]), 64'(be1));
      check("pt1_frame_err", 64'(fe_q[b_st + 1]), 64'(fe1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CL-1:0] flip2, ones;
    int b_st, b_sd, b_ack, b_dack;
    flip2      = '0;
    flip2[0]   = 1'b1;
    flip2[255] = 1'b1;
    ones       = '1;

    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b1;
    tick();

    // Echo decoder, encoder pre-asserted before start, slow decoder accept on frame 1.
    #2; b_st = be_q.size(); b_sd = sd_cnt; b_ack = ack_cnt; b_dack = dack_cnt;
    do_sweep(IT, -1, -1, '0, 1, 1'b1);
    expect_sweep(b_st, b_sd, b_ack, b_dack, IT * ST, 0, 0, 0, 0);

    // Bits 0 and 255 wrong on frame 2 of point 1.
    tick();
    #2; b_st = be_q.size(); b_sd = sd_cnt; b_ack = ack_cnt; b_dack = dack_cnt;
    do_sweep(IT, 1, 2, flip2, -1, 1'b0);
    expect_sweep(b_st, b_sd, b_ack, b_dack, IT * ST, 0, 0, 2, 1);

    // Reset while waiting for decoder result.
    tick();
    #2; b_st = be_q.size(); b_sd = sd_cnt;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    Code_sequence      = rand_cw();
    generate_code_down = 1'b1;
    wait_sig(0, "abort_ack_timeout");
    tick();
    generate_code_down = 1'b0;
    dec_start_receive  = 1'b1;
    tick();
    dec_start_receive = 1'b0;
    tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #2;
    check_outputs_zero("async_rst");
    dec_done = 1'b1;
    tick();
    tick();
    dec_done = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    #2;
    check("abort_no_stat", 64'(be_q.size() - b_st), 64'd0);
    check("abort_no_done", 64'(sd_cnt - b_sd), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    // Clean sweep after the abort.
    #2; b_st = be_q.size(); b_sd = sd_cnt; b_ack = ack_cnt; b_dack = dack_cnt;
    tick();
    do_sweep(IT, -1, -1, '0, -1, 1'b0);
    expect_sweep(b_st, b_sd, b_ack, b_dack, IT * ST, 0, 0, 0, 0);

`ifdef LDPC_EARLY_STOP_EN
    // Every bit wrong: each point ends after FER_THRESH=2 frames.
    tick();
    #2; b_st = be_q.size(); b_sd = sd_cnt; b_ack = ack_cnt; b_dack = dack_cnt;
    do_sweep(2, -1, -1, ones, -1, 1'b0);
    expect_sweep(b_st, b_sd, b_ack, b_dack, 2 * ST, 512, 2, 512, 2);
`else
    check("ones_flip_width", 64'(ones[CL-1]), 64'd1);
`endif

    check("sigma_stable_during_offer", 64'(sig_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
